vga_sync_decoder: RTL and testbench
===================================

// Module: vga_sync_decoder
// PURPOSE
//   Receive-side counterpart of the VGA timing generator. Samples HS/VS,
//   measures line length, HS pulse width and lines per frame, and recovers
//   pixel/line position. Declares lock after consecutive identical frames.
//   Used as an on-chip self-check of the sync path and as a sink for
//   externally timed video.
// PARAMETERS
//   CW           11  width of all pixel/line counters and measurements
//   SYNC_POL     1   active level of hs_in/vs_in (1 = active-high)
//   LOCK_FRAMES  2   consecutive matching frames required to assert locked
// PORTS
//   clk          in   1   100 MHz system clock
//   rst          in   1   synchronous active-high reset
//   pix_en       in   1   pixel-rate strobe (1 clk in 4); all counting is gated by it
//   hs_in        in   1   horizontal sync, asynchronous to clk
//   vs_in        in   1   vertical sync, asynchronous to clk
//   h_pos        out  CW  pixels since last HS leading edge
//   v_pos        out  CW  HS leading edges since last VS leading edge
//   line_len     out  CW  last measured HS leading-to-leading period, in pixels
//   hs_width     out  CW  last measured HS active width, in pixels
//   frame_lines  out  CW  last measured lines per frame
//   locked       out  1   timing stable (state LOCKED)
//   err          out  1   one-clk pulse on loss of lock or on timeout
// BEHAVIOUR
//   - Reset: every output, counter and reference register 0; state SEARCH.
//   - Input path: 2-FF synchroniser on every clk. Edge detection compares the
//     synchronised value with the previous sample taken on a pix_en cycle.
//     Leading edge = inactive->active. Latency from pin to edge is 2 clk plus
//     up to one pix_en period.
//   - pix_en low: counters, measurements and FSM hold. Synchronisers still run.
//   - h_pos: on an HS leading edge, line_len <= h_pos+1 and h_pos <= 0.
//     Otherwise h_pos increments and saturates at 2^CW-1.
//     On an HS trailing edge, hs_width <= h_pos+1.
//   - v_pos: increments (saturating) on each HS leading edge.
//     On a VS leading edge, frame_lines <= v_pos and v_pos <= 0.
//     When VS and HS leading edges occur on the same pix_en cycle, VS wins:
//     v_pos <= 0 and frame_lines captures the pre-increment value.
//   - FSM states (advance only on pix_en cycles):
//     SEARCH: first VS leading edge -> TRACK, match_cnt <= 0, ref_valid <= 0.
//     TRACK: each VS leading edge loads ref_line/ref_frame from the new
//       line_len/frame_lines. If ref_valid and both values equal the previous
//       refs, match_cnt++; otherwise match_cnt <= 0. ref_valid <= 1.
//       When match_cnt reaches LOCK_FRAMES -> LOCKED.
//     LOCKED: each HS leading edge checks new line_len against ref_line. Each VS
//       leading edge checks new frame_lines against ref_frame. Any mismatch:
//       err pulse, go to TRACK, match_cnt <= 0, refs reloaded with the new values.
//     Timeout in any state: h_pos saturated, or v_pos saturated.
//       Action: err pulse (LOCKED only), go to SEARCH, clear refs.
//   - locked = (state == LOCKED), registered. err is high for exactly one clk.
//   - rst mid-frame: all state cleared the next clk; lock must be reacquired from SEARCH.
// STRUCTURE
//   - Package vga_pkg: CW default; state type (SEARCH, TRACK, LOCKED) as
//     localparams; 640x480 timing constants (800/96/525/2) shared with the
//     generator and the bench.
//   - Sub-module sync_edge_det (2-FF sync, pix_en-gated sample, rise/fall
//     pulses, SYNC_POL applied), instantiated for HS and VS. Counters and FSM
//     live in the top module.
// TESTING
//   1. rst 1 for 3 clk; then frames of 800 px, HS 96, 525 lines, VS 2 lines,
//      pix_en every 4th clk.
//      -> line_len=800, hs_width=96, frame_lines=525; locked rises at the 4th
//      VS leading edge.
//   2. While locked, stretch one line to 801 px -> err is 1 clk wide, locked=0,
//      relocks 2 frames later.
//   3. Hold hs_in inactive for 2100 pixel strobes -> h_pos sticks at 2047,
//      err pulses once, state SEARCH, locked=0.
//   4. HS and VS leading edges on the same pix_en cycle -> v_pos=0,
//      frame_lines=525 (not 526).
//   5. Assert rst mid-line while locked -> next clk all outputs 0; locked
//      returns only after 4 further VS edges.
//   6. pix_en held 0 for 1000 clk mid-line -> h_pos, v_pos and state unchanged;
//      counting resumes from the same values.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA sync path: counter width, decoder states and
// the 640x480 raster constants used by the generator and the decoder.
package vga_pkg;

  localparam int CW_DEF = 11;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int H_TOTAL = 800;
  localparam int H_SYNC  = 96;
  localparam int V_TOTAL = 525;
  localparam int V_SYNC  = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Brings one sync input into the clk domain and reports its leading/trailing
// edges, judged against the level last seen on a pixel strobe.
module sync_edge_det import vga_pkg::*; #(
  parameter bit SYNC_POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_pipe;
  logic       act;
  logic       prev;

  // Synchroniser runs every clk; only the edge reference waits for pix_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_pipe <= '0;
      prev      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], din};
      if (pix_en) prev <= act;
    end
  end

  assign act  = (sync_pipe[1] == SYNC_POL);
  assign rise = pix_en & act & ~prev;
  assign fall = pix_en & ~act & prev;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing checker: measures line/pulse/frame lengths, tracks
// pixel and line position, and declares lock after repeated identical frames.
module vga_sync_decoder import vga_pkg::*; #(
  parameter int CW          = CW_DEF,
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          hs_in,
  input  logic          vs_in,
  output logic [CW-1:0] h_pos,
  output logic [CW-1:0] v_pos,
  output logic [CW-1:0] line_len,
  output logic [CW-1:0] hs_width,
  output logic [CW-1:0] frame_lines,
  output logic          locked,
  output logic          err
);

  localparam int NUM_SYNC = 2;
  localparam int MW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [NUM_SYNC-1:0] sync_raw, rise, fall;
  logic                hs_rise, hs_fall, vs_rise;
  logic                unused_vs_fall;

  assign sync_raw = {vs_in, hs_in};

  for (genvar i = 0; i < NUM_SYNC; i++) begin : g_sync
    sync_edge_det #(.SYNC_POL(SYNC_POL)) u_det (
      .clk    (clk),
      .rst    (rst),
      .pix_en (pix_en),
      .din    (sync_raw[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  assign hs_rise        = rise[0];
  assign hs_fall        = fall[0];
  assign vs_rise        = rise[1];
  assign unused_vs_fall = fall[1];

  logic          h_sat, v_sat, timeout;
  logic [CW-1:0] line_len_new, frame_lines_new;

  assign h_sat   = (h_pos == CNT_MAX);
  assign v_sat   = (v_pos == CNT_MAX);
  assign timeout = h_sat | v_sat;

  // Values the measurement registers take this strobe; the FSM judges these.
  assign line_len_new    = hs_rise ? h_pos + CW'(1) : line_len;
  assign frame_lines_new = vs_rise ? v_pos : frame_lines;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_pos       <= '0;
      v_pos       <= '0;
      line_len    <= '0;
      hs_width    <= '0;
      frame_lines <= '0;
    end else if (pix_en) begin
      if (hs_rise) begin
        h_pos    <= '0;
        line_len <= line_len_new;
      end else if (!h_sat) begin
        h_pos <= h_pos + CW'(1);
      end
      if (hs_fall) hs_width <= h_pos + CW'(1);
      // VS outranks a coincident HS so frame_lines sees the pre-increment count.
      if (vs_rise) begin
        v_pos       <= '0;
        frame_lines <= v_pos;
      end else if (hs_rise && !v_sat) begin
        v_pos <= v_pos + CW'(1);
      end
    end
  end

  state_t        state, state_nxt;
  logic [MW-1:0] match_cnt, match_nxt;
  logic          ref_valid, rvalid_nxt;
  logic [CW-1:0] ref_line, ref_line_nxt;
  logic [CW-1:0] ref_frame, ref_frame_nxt;
  logic          err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SEARCH;
      match_cnt <= '0;
      ref_valid <= 1'b0;
      ref_line  <= '0;
      ref_frame <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      ref_valid <= rvalid_nxt;
      ref_line  <= ref_line_nxt;
      ref_frame <= ref_frame_nxt;
      locked    <= (state_nxt == ST_LOCKED);
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    match_nxt     = match_cnt;
    rvalid_nxt    = ref_valid;
    ref_line_nxt  = ref_line;
    ref_frame_nxt = ref_frame;
    err_nxt       = 1'b0;
    if (pix_en) begin
      if (timeout) begin
        err_nxt       = (state == ST_LOCKED);
        state_nxt     = ST_SEARCH;
        match_nxt     = '0;
        rvalid_nxt    = 1'b0;
        ref_line_nxt  = '0;
        ref_frame_nxt = '0;
      end else begin
        case (state)
          ST_SEARCH: begin
            if (vs_rise) begin
              state_nxt  = ST_TRACK;
              match_nxt  = '0;
              rvalid_nxt = 1'b0;
            end
          end
          ST_TRACK: begin
            if (vs_rise) begin
              ref_line_nxt  = line_len_new;
              ref_frame_nxt = frame_lines_new;
              rvalid_nxt    = 1'b1;
              if (ref_valid && line_len_new == ref_line &&
                  frame_lines_new == ref_frame) begin
                match_nxt = match_cnt + MW'(1);
                if (match_nxt == MW'(LOCK_FRAMES)) state_nxt = ST_LOCKED;
              end else begin
                match_nxt = '0;
              end
            end
          end
          ST_LOCKED: begin
            if ((hs_rise && line_len_new != ref_line) ||
                (vs_rise && frame_lines_new != ref_frame)) begin
              err_nxt       = 1'b1;
              state_nxt     = ST_TRACK;
              match_nxt     = '0;
              rvalid_nxt    = 1'b1;
              ref_line_nxt  = line_len_new;
              ref_frame_nxt = frame_lines_new;
            end
          end
          default: state_nxt = ST_SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced raster (40 px lines, 6 px
// HS, 12 lines, 2-line VS) so each frame costs under 2k clk.
module tb_vga_sync_decoder;

  localparam int CW    = 11;
  localparam int H_TOT = 40;
  localparam int H_SY  = 6;
  localparam int V_TOT = 12;
  localparam int V_SY  = 2;
  localparam int HALF  = H_TOT / 2;

  logic          clk = 1'b0, rst = 1'b1, pix_en = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [CW-1:0] h_pos, v_pos, line_len, hs_width, frame_lines;
  logic          locked, err;

  vga_sync_decoder #(.CW(CW), .SYNC_POL(1'b1), .LOCK_FRAMES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .h_pos       (h_pos),
    .v_pos       (v_pos),
    .line_len    (line_len),
    .hs_width    (hs_width),
    .frame_lines (frame_lines),
    .locked      (locked),
    .err         (err)
  );

  always #5 clk = ~clk;

  int   errors = 0, checks = 0;
  int   err_pulses = 0, err_hi = 0;
  logic err_d = 1'b0;

  always @(posedge clk) begin
    err_d <= err;
    if (err) err_hi <= err_hi + 1;
    if (err && !err_d) err_pulses <= err_pulses + 1;
  end

  // Raster generator state; (pv,ph) is the last pixel handed to the DUT.
  int hc, vc, cur_len, pv, ph, vs_edges;
  bit stretch_req, hs_kill, vs_kill, coin, vs_lvl_d;

  function automatic bit hs_lvl();
    return !hs_kill && (hc < H_SY);
  endfunction

  function automatic bit vs_lvl();
    if (vs_kill) return 1'b0;
    if (coin) return vc < V_SY;
    return (vc == V_TOT-1 && hc >= HALF) || (vc < V_SY-1) || (vc == V_SY-1 && hc < HALF);
  endfunction

  // Expected v_pos after pixel (pv,ph) with VS leading mid-way through the last line.
  function automatic int vpos_model();
    return (pv == V_TOT-1 && ph >= HALF) ? 0 : pv + 1;
  endfunction

  string       tag_q[$];
  logic [31:0] exp_q[$];

  task automatic expect_v(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_next(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed=%0d with no expectation queued", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", t, obs, e);
    end
  endtask

  // One pixel: levels change, sync settles, then a single-clk pix_en strobe.
  task automatic pixel();
    hs_in = hs_lvl();
    vs_in = vs_lvl();
    if (vs_in && !vs_lvl_d) vs_edges++;
    vs_lvl_d = vs_in;
    pv = vc;
    ph = hc;
    repeat (3) @(posedge clk);
    #1 pix_en = 1'b1;
    @(posedge clk);
    #1 pix_en = 1'b0;
    hc++;
    if (hc == cur_len) begin
      hc = 0;
      vc = (vc + 1) % V_TOT;
      cur_len = stretch_req ? H_TOT + 1 : H_TOT;
      stretch_req = 1'b0;
    end
  endtask

  task automatic run_to_vs(input int n);
    int target = vs_edges + n;
    int budget = n * 2 * (H_TOT + 1) * V_TOT;
    while (vs_edges < target && budget > 0) begin
      pixel();
      budget--;
    end
    if (vs_edges < target) begin
      checks++;
      errors++;
      $display("FAIL vs_wait: observed=%0d edges required=%0d", vs_edges, target);
    end
  endtask

  task automatic run_until(input int v, input int h);
    int budget = 3 * (H_TOT + 1) * V_TOT;
    do begin
      pixel();
      budget--;
    end while (!(pv == v && ph == h) && budget > 0);
    if (!(pv == v && ph == h)) begin
      checks++;
      errors++;
      $display("FAIL pos_wait: observed=%0d,%0d required=%0d,%0d", pv, ph, v, h);
    end
  endtask

  task automatic expect_all_zero(input string pfx);
    expect_v({pfx, "_h_pos"}, 0);
    expect_v({pfx, "_v_pos"}, 0);
    expect_v({pfx, "_line_len"}, 0);
    expect_v({pfx, "_hs_width"}, 0);
    expect_v({pfx, "_frame_lines"}, 0);
    expect_v({pfx, "_locked"}, 0);
    expect_v({pfx, "_err"}, 0);
    check_next(h_pos);
    check_next(v_pos);
    check_next(line_len);
    check_next(hs_width);
    check_next(frame_lines);
    check_next(locked);
    check_next(err);
  endtask

  initial begin
    int base_p, base_h, tries;
    hc = 0; vc = V_SY; cur_len = H_TOT; pv = 0; ph = 0; vs_edges = 0;
    stretch_req = 0; hs_kill = 0; vs_kill = 0; coin = 0; vs_lvl_d = 0;

    // Reset held for 3 clk
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_all_zero("reset");
    rst = 1'b0;

    // Acquisition: lock on the 4th VS leading edge
    expect_v("t1_locked_after_3vs", 0);
    run_to_vs(3);
    check_next(locked);
    expect_v("t1_locked_after_4vs", 1);
    expect_v("t1_line_len", H_TOT);
    expect_v("t1_hs_width", H_SY);
    expect_v("t1_frame_lines", V_TOT);
    expect_v("t1_h_pos", HALF);
    expect_v("t1_v_pos", 0);
    expect_v("t1_err_pulses", 0);
    run_to_vs(1);
    check_next(locked);
    check_next(line_len);
    check_next(hs_width);
    check_next(frame_lines);
    check_next(h_pos);
    check_next(v_pos);
    check_next(err_pulses);

    // One line stretched by a pixel while locked
    base_p = err_pulses;
    base_h = err_hi;
    stretch_req = 1'b1;
    expect_v("t2_err_high", 1);
    expect_v("t2_line_len", H_TOT + 1);
    expect_v("t2_locked_drop", 0);
    run_until(1, 0);
    check_next(err);
    check_next(line_len);
    check_next(locked);
    @(posedge clk);
    #1;
    expect_v("t2_err_low", 0);
    expect_v("t2_err_pulses", base_p + 1);
    expect_v("t2_err_width", base_h + 1);
    check_next(err);
    check_next(err_pulses);
    check_next(err_hi);
    expect_v("t2_locked_after_2vs", 0);
    run_to_vs(2);
    check_next(locked);
    expect_v("t2_relocked", 1);
    run_to_vs(1);
    check_next(locked);

    // pix_en stall for 1000 clk mid-line
    run_until(4, 17);
    expect_v("t6_h_hold", ph);
    expect_v("t6_v_hold", vpos_model());
    expect_v("t6_locked_hold", 1);
    repeat (1000) @(posedge clk);
    #1;
    check_next(h_pos);
    check_next(v_pos);
    check_next(locked);
    pixel();
    expect_v("t6_h_resume", ph);
    expect_v("t6_v_resume", vpos_model());
    check_next(h_pos);
    check_next(v_pos);

    // Sync lost: h_pos saturates and times out
    base_p = err_pulses;
    base_h = err_hi;
    hs_kill = 1'b1;
    vs_kill = 1'b1;
    expect_v("t3_h_pos_sat", (1 << CW) - 1);
    expect_v("t3_locked", 0);
    expect_v("t3_err_pulses", base_p + 1);
    expect_v("t3_err_width", base_h + 1);
    repeat (2100) pixel();
    check_next(h_pos);
    check_next(locked);
    check_next(err_pulses);
    check_next(err_hi);

    // VS and HS leading edges on the same strobe
    hs_kill = 1'b0;
    run_until(5, 0);
    vs_kill = 1'b0;
    run_to_vs(1);
    vs_kill = 1'b1;
    run_until(5, 0);
    coin = 1'b1;
    vs_kill = 1'b0;
    expect_v("t4_v_pos", 0);
    expect_v("t4_frame_lines", V_TOT);
    expect_v("t4_h_pos", 0);
    run_to_vs(1);
    check_next(v_pos);
    check_next(frame_lines);
    check_next(h_pos);
    coin = 1'b0;

    // Relock on normal timing (bounded)
    tries = 0;
    while (!locked && tries < 8) begin
      run_to_vs(1);
      tries++;
    end
    expect_v("t5_prelock", 1);
    check_next(locked);

    // Reset mid-line while locked
    run_until(3, 10);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expect_all_zero("t5_midreset");
    expect_v("t5_locked_after_3vs", 0);
    run_to_vs(3);
    check_next(locked);
    expect_v("t5_locked_after_4vs", 1);
    run_to_vs(1);
    check_next(locked);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
